// File: rtl/csr_hpm_counters.sv
// Machine counters (mcycle/minstret/mhpmcounterN), HPM event selectors and mcountinhibit; reads are combinational, updates land at the clock edge.
// Optional per-counter OF flag and overflow interrupt under `CSR_HPM_OVERFLOW_IRQ_EN; no backpressure, every access completes in its cycle.
module csr_hpm_counters #(
  parameter int XLEN       = 32,
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_csr_read_enable,
  input  logic [11:0]           i_csr_address,
  input  logic [2:0]            i_csr_op,
  input  logic [XLEN-1:0]       i_csr_write_data,
  input  logic                  i_csr_write_enable,
  output logic [XLEN-1:0]       o_csr_read_data,
  output logic                  o_csr_hit,
  input  logic                  i_instruction_retired,
  input  logic [NUM_EVENTS-1:0] i_events,
  output logic                  o_overflow_irq
);

  localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] INH_MASK = 32'h5 | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [63:0] ext64(input logic [CNT_WIDTH-1:0] v);
    return 64'(v);
  endfunction

  // Replace one 32-bit half of a counter, keeping the other half.
  function automatic logic [CNT_WIDTH-1:0] merge(input logic [CNT_WIDTH-1:0] cur,
                                                 input logic hi, input logic [31:0] v);
    logic [63:0] c;
    c = 64'(cur);
    if (hi) c[63:32] = v;
    else    c[31:0]  = v;
    return CNT_WIDTH'(c);
  endfunction

  logic [CNT_WIDTH-1:0] r_mcycle;
  logic [CNT_WIDTH-1:0] r_minstret;
  logic [CNT_WIDTH-1:0] r_hpm [NH];
  logic [7:0]           r_evsel [NH];
  logic [31:0]          r_inhibit;

  logic [4:0]      w_idx;
  logic            w_is_hi;
  logic            w_cnt_space;
  logic            w_cnt_rw;
  logic            w_cfg_space;
  logic            w_sel_cyc;
  logic            w_sel_ins;
  logic            w_sel_inh;
  logic [NH-1:0]   w_sel_hpm;
  logic [NH-1:0]   w_sel_ev;
  logic            w_dec;
  logic            w_hit;
  logic            w_wr_ok;
  logic [63:0]     w_cnt64;
  logic [XLEN-1:0] w_cur;
  logic [XLEN-1:0] w_new;
  logic [NH-1:0]   w_of;
  logic [NH-1:0]   w_ev_hit;
  logic [NH-1:0]   w_inc_hpm;
  logic [NH-1:0]   w_wrap;
  logic            w_unused;

  assign w_idx       = i_csr_address[4:0];
  assign w_is_hi     = i_csr_address[7];
  assign w_cnt_space = ((i_csr_address[11:8] == 4'hB) || (i_csr_address[11:8] == 4'hC)) &&
                       (i_csr_address[6:5] == 2'b00);
  assign w_cnt_rw    = (i_csr_address[11:8] == 4'hB);
  assign w_cfg_space = (i_csr_address[11:5] == 7'h19);

  always_comb begin
    w_sel_cyc = w_cnt_space && (w_idx == 5'd0);
    w_sel_ins = w_cnt_space && (w_idx == 5'd2);
    w_sel_inh = w_cfg_space && (w_idx == 5'd0);
    w_sel_hpm = '0;
    w_sel_ev  = '0;
    for (int k = 0; k < NUM_HPM; k++) begin
      w_sel_hpm[k] = w_cnt_space && (w_idx == 5'(k + 3));
      w_sel_ev[k]  = w_cfg_space && (w_idx == 5'(k + 3));
    end
  end

  assign w_dec   = w_sel_cyc | w_sel_ins | w_sel_inh | (|w_sel_hpm) | (|w_sel_ev);
  assign w_hit   = w_dec & i_csr_read_enable;
  assign w_wr_ok = i_csr_read_enable & i_csr_write_enable & w_dec &
                   (w_cnt_rw | w_cfg_space) & (i_csr_op[1:0] != 2'b00);

  always_comb begin
    w_cnt64 = '0;
    if (w_sel_cyc) w_cnt64 = ext64(r_mcycle);
    if (w_sel_ins) w_cnt64 = ext64(r_minstret);
    for (int k = 0; k < NUM_HPM; k++)
      if (w_sel_hpm[k]) w_cnt64 = ext64(r_hpm[k]);
    w_cur = w_is_hi ? w_cnt64[63:32] : w_cnt64[31:0];
    if (w_sel_inh) w_cur = r_inhibit;
    for (int k = 0; k < NUM_HPM; k++)
      if (w_sel_ev[k]) w_cur = {w_of[k], 23'd0, r_evsel[k]};
  end

  always_comb begin
    case (i_csr_op[1:0])
      2'b01:   w_new = i_csr_write_data;
      2'b10:   w_new = w_cur | i_csr_write_data;
      2'b11:   w_new = w_cur & ~i_csr_write_data;
      default: w_new = w_cur;
    endcase
  end

  assign o_csr_hit       = w_hit & ~i_rst;
  assign o_csr_read_data = (w_hit && !i_rst) ? w_cur : '0;

  // Selector 0 matches no event, so the scan starts at 1.
  always_comb begin
    w_ev_hit  = '0;
    w_inc_hpm = '0;
    w_wrap    = '0;
    for (int k = 0; k < NUM_HPM; k++) begin
      for (int e = 1; e <= NUM_EVENTS; e++)
        if ((r_evsel[k] == 8'(e)) && i_events[e-1]) w_ev_hit[k] = 1'b1;
      w_inc_hpm[k] = w_ev_hit[k] & ~r_inhibit[k+3];
      w_wrap[k]    = w_inc_hpm[k] & (&r_hpm[k]) & ~(w_wr_ok & w_sel_hpm[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
      r_inhibit  <= '0;
      for (int k = 0; k < NH; k++) begin
        r_hpm[k]   <= '0;
        r_evsel[k] <= '0;
      end
    end else begin
      if (w_wr_ok && w_sel_cyc)   r_mcycle <= merge(r_mcycle, w_is_hi, w_new);
      else if (!r_inhibit[0])     r_mcycle <= r_mcycle + CNT_ONE;

      if (w_wr_ok && w_sel_ins)                       r_minstret <= merge(r_minstret, w_is_hi, w_new);
      else if (i_instruction_retired && !r_inhibit[2]) r_minstret <= r_minstret + CNT_ONE;

      if (w_wr_ok && w_sel_inh) r_inhibit <= w_new & INH_MASK;

      for (int k = 0; k < NUM_HPM; k++) begin
        if (w_wr_ok && w_sel_hpm[k]) r_hpm[k] <= merge(r_hpm[k], w_is_hi, w_new);
        else if (w_inc_hpm[k])       r_hpm[k] <= r_hpm[k] + CNT_ONE;
        if (w_wr_ok && w_sel_ev[k])
          r_evsel[k] <= (w_new[7:0] > 8'(NUM_EVENTS)) ? 8'd0 : w_new[7:0];
      end
    end
  end

`ifdef CSR_HPM_OVERFLOW_IRQ_EN
  logic [NH-1:0] r_of;
  logic          r_irq;

  // A wrap in the same cycle as a software clear wins, so no overflow is lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_of  <= '0;
      r_irq <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_HPM; k++) begin
        if (w_wrap[k])                   r_of[k] <= 1'b1;
        else if (w_wr_ok && w_sel_ev[k]) r_of[k] <= w_new[31];
      end
      r_irq <= |r_of;
    end
  end

  assign w_of           = r_of;
  assign o_overflow_irq = r_irq & ~i_rst;
  assign w_unused       = i_csr_op[2];
`else
  assign w_of           = '0;
  assign o_overflow_irq = 1'b0;
  assign w_unused       = i_csr_op[2] ^ (|w_wrap);
`endif

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Directed plus randomized bench for csr_hpm_counters against a spec-level counter model.
module tb_csr_hpm_counters;
  localparam int XLEN       = 32;
  localparam int NUM_HPM    = 4;
  localparam int CNT_WIDTH  = 64;
  localparam int NUM_EVENTS = 16;
`ifdef CSR_HPM_OVERFLOW_IRQ_EN
  localparam bit OF_EN = 1'b1;
`else
  localparam bit OF_EN = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_csr_read_enable;
  logic [11:0]           i_csr_address;
  logic [2:0]            i_csr_op;
  logic [XLEN-1:0]       i_csr_write_data;
  logic                  i_csr_write_enable;
  logic [XLEN-1:0]       o_csr_read_data;
  logic                  o_csr_hit;
  logic                  i_instruction_retired;
  logic [NUM_EVENTS-1:0] i_events;
  logic                  o_overflow_irq;

  csr_hpm_counters #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH), .NUM_EVENTS(NUM_EVENTS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_csr_read_enable(i_csr_read_enable),
    .i_csr_address(i_csr_address), .i_csr_op(i_csr_op), .i_csr_write_data(i_csr_write_data),
    .i_csr_write_enable(i_csr_write_enable), .o_csr_read_data(o_csr_read_data),
    .o_csr_hit(o_csr_hit), .i_instruction_retired(i_instruction_retired),
    .i_events(i_events), .o_overflow_irq(o_overflow_irq));

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: plain 64-bit counters, selector numbers, OF flags, inhibit word.
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hpm [NUM_HPM];
  int          m_sel [NUM_HPM];
  bit          m_of  [NUM_HPM];
  logic [31:0] m_inh;
  bit          m_irq;
  logic [31:0] inh_mask;

  localparam int NADDR = 22;
  logic [11:0] addrs [NADDR] = '{12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04,
                                 12'hB05, 12'hB06, 12'hB83, 12'hB86, 12'hB07, 12'hB01,
                                 12'hC00, 12'hC80, 12'hC03, 12'hC86};
  logic [2:0] ops [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  task automatic model_reset();
    m_cyc = '0; m_ins = '0; m_inh = '0; m_irq = 1'b0;
    for (int k = 0; k < NUM_HPM; k++) begin
      m_hpm[k] = '0; m_sel[k] = 0; m_of[k] = 1'b0;
    end
  endtask

  function automatic logic [32:0] mread(input logic [11:0] a);
    logic [63:0] c;
    logic [11:0] base;
    if (a == 12'h320) return {1'b1, m_inh};
    for (int k = 0; k < NUM_HPM; k++)
      if (a == 12'h323 + 12'(k)) return {1'b1, m_of[k], 23'd0, 8'(m_sel[k])};
    for (int i = 0; i < 3 + NUM_HPM; i++) begin
      if (i == 1) continue;
      if (i == 0)      c = m_cyc;
      else if (i == 2) c = m_ins;
      else             c = m_hpm[i-3];
      for (int b = 0; b < 2; b++) begin
        base = (b == 0) ? 12'hB00 : 12'hC00;
        if (a == base + 12'(i))           return {1'b1, c[31:0]};
        if (a == base + 12'h080 + 12'(i)) return {1'b1, c[63:32]};
      end
    end
    return 33'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, applying the counter rules to the inputs currently driven.
  task automatic step();
    logic [32:0] r;
    logic [31:0] nv, wd;
    logic [11:0] a;
    bit          wr, rst, ev;
    logic [63:0] n_cyc, n_ins;
    logic [63:0] n_hpm [NUM_HPM];
    int          n_sel [NUM_HPM];
    bit          n_of  [NUM_HPM];
    bit          wrapped [NUM_HPM];
    logic [31:0] n_inh;
    bit          n_irq;
    rst = i_rst;
    a   = i_csr_address;
    wd  = i_csr_write_data;
    r   = mread(a);
    wr  = i_csr_read_enable && i_csr_write_enable && r[32] && (a[11:8] != 4'hC);
    case (i_csr_op[1:0])
      2'b01:   nv = wd;
      2'b10:   nv = r[31:0] | wd;
      2'b11:   nv = r[31:0] & ~wd;
      default: begin nv = r[31:0]; wr = 1'b0; end
    endcase
    n_cyc = m_inh[0] ? m_cyc : m_cyc + 64'd1;
    n_ins = (i_instruction_retired && !m_inh[2]) ? m_ins + 64'd1 : m_ins;
    n_inh = m_inh;
    n_irq = 1'b0;
    for (int k = 0; k < NUM_HPM; k++) begin
      n_sel[k] = m_sel[k];
      n_of[k]  = m_of[k];
      ev = (m_sel[k] != 0) && i_events[m_sel[k]-1] && !m_inh[3+k];
      n_hpm[k]   = ev ? m_hpm[k] + 64'd1 : m_hpm[k];
      wrapped[k] = ev && (m_hpm[k] == 64'hFFFF_FFFF_FFFF_FFFF);
      n_irq = n_irq | m_of[k];
    end
    if (wr) begin
      if (a == 12'h320) n_inh = nv & inh_mask;
      if (a == 12'hB00) n_cyc = {m_cyc[63:32], nv};
      if (a == 12'hB80) n_cyc = {nv, m_cyc[31:0]};
      if (a == 12'hB02) n_ins = {m_ins[63:32], nv};
      if (a == 12'hB82) n_ins = {nv, m_ins[31:0]};
      for (int k = 0; k < NUM_HPM; k++) begin
        if (a == 12'hB03 + 12'(k)) begin n_hpm[k] = {m_hpm[k][63:32], nv}; wrapped[k] = 1'b0; end
        if (a == 12'hB83 + 12'(k)) begin n_hpm[k] = {nv, m_hpm[k][31:0]}; wrapped[k] = 1'b0; end
        if (a == 12'h323 + 12'(k)) begin
          n_sel[k] = (int'(nv[7:0]) > NUM_EVENTS) ? 0 : int'(nv[7:0]);
          if (OF_EN) n_of[k] = nv[31];
        end
      end
    end
    for (int k = 0; k < NUM_HPM; k++)
      if (OF_EN && wrapped[k]) n_of[k] = 1'b1;
    @(posedge i_clk);
    #1;
    if (rst) model_reset();
    else begin
      m_cyc = n_cyc; m_ins = n_ins; m_inh = n_inh; m_irq = OF_EN ? n_irq : 1'b0;
      for (int k = 0; k < NUM_HPM; k++) begin
        m_hpm[k] = n_hpm[k]; m_sel[k] = n_sel[k]; m_of[k] = n_of[k];
      end
    end
    i_csr_write_enable    = 1'b0;
    i_events              = '0;
    i_instruction_retired = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    i_csr_read_enable  = 1'b1;
    i_csr_address      = a;
    i_csr_op           = op;
    i_csr_write_data   = d;
    i_csr_write_enable = 1'b1;
    step();
  endtask

  task automatic peek(input logic [11:0] a, input string tag);
    logic [32:0] r;
    i_csr_read_enable  = 1'b1;
    i_csr_write_enable = 1'b0;
    i_csr_address      = a;
    #1;
    r = mread(a);
    chk({tag, "_hit"}, 32'(o_csr_hit), 32'(r[32]));
    chk(tag, o_csr_read_data, r[31:0]);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    inh_mask = 32'h5;
    for (int k = 0; k < NUM_HPM; k++) inh_mask[3+k] = 1'b1;
    model_reset();
    i_rst = 1'b1; i_csr_read_enable = 1'b0; i_csr_address = '0; i_csr_op = 3'b001;
    i_csr_write_data = '0; i_csr_write_enable = 1'b0; i_instruction_retired = 1'b0; i_events = '0;

    // Reset, outputs held low while reset is high
    step();
    step();
    i_csr_read_enable = 1'b1; i_csr_address = 12'hB00;
    #1;
    chk("rst_hit", 32'(o_csr_hit), 32'd0);
    chk("rst_data", o_csr_read_data, 32'd0);
    chk("rst_irq", 32'(o_overflow_irq), 32'd0);
    i_rst = 1'b0;
    for (int n = 0; n < 10; n++) step();
    peek(12'hB00, "idle_mcycle");
    chk("idle_mcycle_10", o_csr_read_data, 32'd10);
    peek(12'hC00, "idle_cycle");
    chk("idle_cycle_10", o_csr_read_data, 32'd10);
    peek(12'hB02, "idle_minstret");
    peek(12'hB03, "idle_hpm3");
    peek(12'h323, "idle_ev3");
    peek(12'hB00 + 12'(3 + NUM_HPM), "miss_hpm");
    chk("miss_hit_const", 32'(o_csr_hit), 32'd0);
    step();

    // Carry out of the low half and write precedence over increment
    csr_wr(12'hB80, 3'b001, 32'h1);
    csr_wr(12'hB00, 3'b001, 32'hFFFF_FFFF);
    step();
    peek(12'hB00, "carry_lo");
    chk("carry_lo_const", o_csr_read_data, 32'd0);
    peek(12'hB80, "carry_hi");
    chk("carry_hi_const", o_csr_read_data, 32'd2);

    // Event counting, inhibit, WARL selector
    csr_wr(12'h323, 3'b001, 32'd2);
    for (int n = 0; n < 5; n++) begin i_events = 16'h2; step(); end
    csr_wr(12'h320, 3'b010, 32'h8);
    for (int n = 0; n < 3; n++) begin i_events = 16'h2; step(); end
    peek(12'hB03, "inh_hpm3");
    chk("inh_hpm3_const", o_csr_read_data, 32'd5);
    csr_wr(12'h323, 3'b001, 32'(NUM_EVENTS + 1));
    peek(12'h323, "warl_sel");
    chk("warl_sel_const", o_csr_read_data, 32'd0);

    // Inhibit written in an event cycle uses the old value; write beats event
    csr_wr(12'h323, 3'b001, 32'd2);
    i_events = 16'h2;
    csr_wr(12'h320, 3'b011, 32'h8);
    peek(12'hB03, "old_inh_hpm3");
    i_events = 16'h2;
    csr_wr(12'hB03, 3'b001, 32'h1234);
    peek(12'hB03, "wr_beats_ev");
    chk("wr_beats_ev_const", o_csr_read_data, 32'h1234);
    peek(12'hB83, "wr_beats_ev_hi");
    csr_wr(12'h320, 3'b110, 32'h4);
    for (int n = 0; n < 3; n++) begin i_instruction_retired = 1'b1; step(); end
    peek(12'hB02, "ir_inhibited");
    chk("ir_inhibited_const", o_csr_read_data, 32'd0);
    csr_wr(12'h320, 3'b111, 32'h4);
    for (int n = 0; n < 2; n++) begin i_instruction_retired = 1'b1; step(); end
    peek(12'hB02, "ir_restored");
    chk("ir_restored_const", o_csr_read_data, 32'd2);

    // Overflow wrap, OF flag and interrupt
    csr_wr(12'hB03, 3'b001, 32'hFFFF_FFFF);
    csr_wr(12'hB83, 3'b001, 32'hFFFF_FFFF);
    i_events = 16'h2;
    step();
    peek(12'hB03, "wrap_lo");
    chk("wrap_lo_const", o_csr_read_data, 32'd0);
    peek(12'hB83, "wrap_hi");
    peek(12'h323, "wrap_of");
    chk("wrap_of_const", o_csr_read_data, {OF_EN, 23'd0, 8'd2});
    chk("irq_not_yet", 32'(o_overflow_irq), 32'd0);
    step();
    chk("irq_rise", 32'(o_overflow_irq), 32'(OF_EN));
    chk("irq_rise_model", 32'(o_overflow_irq), 32'(m_irq));
    csr_wr(12'h323, 3'b011, 32'h8000_0000);
    chk("irq_hold", 32'(o_overflow_irq), 32'(m_irq));
    step();
    chk("irq_drop", 32'(o_overflow_irq), 32'd0);
    peek(12'h323, "of_cleared");
    chk("of_cleared_const", o_csr_read_data, 32'd2);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      i_events = NUM_EVENTS'($urandom);
      i_instruction_retired = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        a = addrs[$urandom_range(0, NADDR - 1)];
        case ($urandom_range(0, 3))
          0:       d = 32'($urandom_range(0, 20));
          1:       d = 32'hFFFF_FFFF;
          default: d = $urandom;
        endcase
        i_csr_read_enable  = ($urandom_range(0, 7) != 0);
        i_csr_address      = a;
        i_csr_op           = ops[$urandom_range(0, 5)];
        i_csr_write_data   = d;
        i_csr_write_enable = 1'b1;
      end
      step();
      peek(addrs[$urandom_range(0, NADDR - 1)], "rnd_a");
      peek(addrs[$urandom_range(0, NADDR - 1)], "rnd_b");
      chk("rnd_irq", 32'(o_overflow_irq), 32'(m_irq));
    end

    // Reset during a pending write clears everything
    i_csr_read_enable = 1'b1; i_csr_address = 12'hB02; i_csr_op = 3'b001;
    i_csr_write_data = 32'h55; i_csr_write_enable = 1'b1; i_events = '1;
    i_instruction_retired = 1'b1; i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    peek(12'hB02, "mrst_minstret");
    chk("mrst_minstret_const", o_csr_read_data, 32'd0);
    peek(12'hB00, "mrst_mcycle");
    chk("mrst_mcycle_const", o_csr_read_data, 32'd0);
    peek(12'h320, "mrst_inhibit");
    peek(12'h323, "mrst_ev3");
    chk("mrst_ev3_const", o_csr_read_data, 32'd0);
    peek(12'hB03, "mrst_hpm3");
    peek(12'hB83, "mrst_hpm3h");
    chk("mrst_irq", 32'(o_overflow_irq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_hpm_counters.md
# csr_hpm_counters

Parametrised machine counter block: the next generation of the Zicntr counter logic inside the CSR file. It adds writable `mcycle`/`minstret`, `NUM_HPM` programmable hardware performance counters with event selectors, and `mcountinhibit`. It sits beside the CSR file on the same EX-stage CSR access bus, and the CSR file ORs `o_csr_read_data` into its read mux when `o_csr_hit` is high. `time`/`timeh` stay in the CSR file.

## Interface
- `XLEN`, 32: CSR data width; only 32 is supported.
- `NUM_HPM`, 4: number of `mhpmcounter`/`mhpmevent` pairs, range 0..29, indexed k = 0..NUM_HPM-1, CSR number 3+k.
- `CNT_WIDTH`, 64: implemented counter width, range 33..64; bits above it read as 0.
- `NUM_EVENTS`, 16: number of event inputs, range 1..255.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_csr_read_enable` in 1: CSR instruction in EX.
- `i_csr_address` in 12: CSR address.
- `i_csr_op` in 3: funct3 (RW=001, RS=010, RC=011, RWI=101, RSI=110, RCI=111).
- `i_csr_write_data` in XLEN: rs1 value or zero-extended immediate.
- `i_csr_write_enable` in 1: commit the write (not stalled or flushed).
- `o_csr_read_data` out XLEN: read value; 0 when there is no hit.
- `o_csr_hit` out 1: address decodes to a CSR in this block and `i_csr_read_enable` is high.
- `i_instruction_retired` in 1: one instruction retires this cycle.
- `i_events` in NUM_EVENTS: per-cycle event pulses.
- `o_overflow_irq` out 1: HPM overflow interrupt request (see Configuration).

## Operation
- Address map:
  - `mcountinhibit` 0x320.
  - `mhpmevent(3+k)` 0x323+k.
  - `mcycle`/`mcycleh` 0xB00/0xB80.
  - `minstret`/`minstreth` 0xB02/0xB82.
  - `mhpmcounter(3+k)`/`h` 0xB03+k / 0xB83+k.
  - Read-only shadows: `cycle` 0xC00/0xC80, `instret` 0xC02/0xC82, `hpmcounter(3+k)` 0xC03+k / 0xC83+k.
- Addresses for k ≥ NUM_HPM are not hits.
- `mcountinhibit` layout:
  - bit0 CY, bit2 IR, bit(3+k) HPMk; all writable.
  - bit1 and unimplemented bits read 0.
- Increment rules:
  - `mcycle` +1 every cycle when CY is 0.
  - `minstret` +1 when `i_instruction_retired` is high and IR is 0.
  - HPMk +1 when `mhpmevent` sel = e (1..NUM_EVENTS), `i_events[e-1]` is high, and HPMk inhibit is 0.
  - sel 0 never counts.
  - Maximum increment is +1 per cycle per counter.
- Event select is `mhpmevent[7:0]`. A written value > NUM_EVENTS stores 0 (WARL). Other bits read 0 except OF (see Configuration).
- Read/modify/write:
  - new value = wdata (RW), cur | wdata (RS), cur & ~wdata (RC).
  - The write occurs when `i_csr_write_enable` and `i_csr_read_enable` are high and the address is a writable hit.
  - Writes to shadows (0xCxx) are ignored.
- Low-half write replaces counter[31:0] and keeps the high half. High-half write replaces counter[CNT_WIDTH-1:32] from wdata[CNT_WIDTH-33:0].
- Write beats increment: a counter written this cycle takes exactly the written value, and that cycle's increment is dropped.
- Counters wrap from all-ones to 0.
- Reset: all counters, `mhpmevent` and `mcountinhibit` are 0. `o_overflow_irq` is 0. Outputs are 0 while `i_rst` is high.

## Timing
- Reads are combinational in the same cycle and return the pre-update value. A write is visible on a read in the next cycle.
- The counter value read at cycle n reflects all increments through the edge ending cycle n-1.
- A 64-bit read via two instructions is not atomic; software uses the hi/lo/hi retry idiom.
- `mcountinhibit` written at edge n: increments stop or start from cycle n+1. An event in the write cycle still uses the old inhibit value.
- `o_overflow_irq` is registered and rises the cycle after the wrapping increment.
- Reset asserted mid-operation clears every state bit at the next edge regardless of pending write or event.

## Configuration
- `CSR_HPM_OVERFLOW_IRQ_EN` defined:
  - `mhpmevent` bit31 is OF, a sticky flag.
  - OF is set when HPMk wraps by increment; a software write that zeroes the counter does not set it.
  - Software writes OF directly. Set-by-wrap and a software clear in the same cycle leave OF set.
  - `o_overflow_irq` = OR of all OF bits.
- `CSR_HPM_OVERFLOW_IRQ_EN` undefined:
  - bit31 reads 0 and is not stored.
  - `o_overflow_irq` is tied 0.

## Test plan
- Reset, then 10 idle cycles: `mcycle` reads 10 at 0xB00 and 0xC00; `minstret`, `mhpmcounter3` and `mhpmevent3` read 0; `o_csr_hit` is 0 for 0xB00+3+NUM_HPM.
- CSRRW `mcycleh`=0x1, then CSRRW `mcycle`=0xFFFFFFFF: after 1 idle cycle `mcycle` reads 0 and `mcycleh` reads 2, confirming carry and write precedence.
- `mhpmevent3`=2, pulse `i_events[1]` 5 times, then CSRRS `mcountinhibit` 0x8 and pulse 3 more: `mhpmcounter3` reads 5. Writing `mhpmevent3`=NUM_EVENTS+1 reads back 0.
- Write `mhpmcounter3` in the same cycle as an active event: reads exactly the written value next cycle. CSRRC on `mcountinhibit` bit2 restores `minstret` counting.
- Macro on: `mhpmcounter3`/`h` = all-ones, one event: counter reads 0, OF reads 1, and `o_overflow_irq` rises 1 cycle later. CSRRC `mhpmevent3` 0x80000000 drops the IRQ. Macro off: bit31 reads 0 and the IRQ stays 0.
- Assert `i_rst` for 1 cycle during a CSRRW to `minstret`: all registers read 0 afterwards.
